// File: rtl/dram_line_pkg.sv
// Shared types and helpers for the DRAM line transfer engine.
package dram_line_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, RD_XFER, WR_XFER, RESP} line_eng_state_t;

  // Width of a beat index for a line of block_size beats.
  function automatic int beat_w(input int block_size);
    return (block_size > 1) ? $clog2(block_size) : 1;
  endfunction

  function automatic logic [63:0] line_align(input logic [63:0] addr, input int block_size);
    logic [63:0] mask;
    mask = 64'(block_size) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/line_beat_counter.sv
// Beat index within a line: clears, advances on enable, flags and wraps at the last beat.
module line_beat_counter
  import dram_line_pkg::*;
#(
  parameter int BLOCK_SIZE = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          clr,
  output logic [beat_w(BLOCK_SIZE)-1:0] beat,
  output logic                          last
);

  localparam int BEAT_W = beat_w(BLOCK_SIZE);

  assign last = (beat == BEAT_W'(BLOCK_SIZE - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      beat <= '0;
    end else if (en) begin
      beat <= last ? '0 : beat + BEAT_W'(1);
    end
  end

endmodule

// File: rtl/dram_line_engine.sv
// Whole-line fill/writeback engine between the cache and a beat-serial DRAM.
// Optional perf counters are built when DRAM_LINE_ENGINE_PERF_EN is defined.
module dram_line_engine
  import dram_line_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_vld,
  output logic                             req_rdy,
  input  logic                             req_is_rd,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] req_wline,
  output logic                             resp_vld,
  input  logic                             resp_rdy,
  output logic [DATA_WIDTH*BLOCK_SIZE-1:0] resp_rline,
  output logic                             mem_is_rd,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic                             mem_cmd_vld,
  input  logic                             mem_cmd_rdy,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic                             mem_rd_rdy,
  input  logic                             mem_rd_vld,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output line_eng_state_t                  dbg_state
`ifdef DRAM_LINE_ENGINE_PERF_EN
  ,
  output logic [31:0]                      perf_rd_cnt,
  output logic [31:0]                      perf_wr_cnt,
  output logic [31:0]                      perf_stall_cnt
`endif
);

  localparam int BEAT_W = beat_w(BLOCK_SIZE);
  localparam int LINE_W = DATA_WIDTH * BLOCK_SIZE;

  line_eng_state_t   state;
  logic [LINE_W-1:0] line;
  logic [LINE_W-1:0] fill_line;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] next_beat;
  logic              last_beat;
  logic              cmd_hs;
  logic              rd_hs;
  logic              beat_en;
  logic              beat_clr;

  // Every channel transfers on a cycle where its valid and ready are both high at
  // the clock edge; valid is held, with its data stable, until that handshake.
  assign req_rdy   = (state == IDLE);
  assign dbg_state = state;
  assign cmd_hs    = mem_cmd_vld && mem_cmd_rdy;
  assign rd_hs     = (state == RD_XFER) && mem_rd_vld;
  assign beat_en   = ((state == WR_XFER) && cmd_hs) || rd_hs;
  assign beat_clr  = (state == ISSUE);
  assign next_beat = beat + BEAT_W'(1);

  always_comb begin
    fill_line = line;
    fill_line[beat*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
  end

  line_beat_counter #(
    .BLOCK_SIZE(BLOCK_SIZE)
  ) u_beat_counter (
    .clk (clk),
    .rst (rst),
    .en  (beat_en),
    .clr (beat_clr),
    .beat(beat),
    .last(last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      line        <= '0;
      resp_rline  <= '0;
      resp_vld    <= 1'b0;
      mem_cmd_vld <= 1'b0;
      mem_rd_rdy  <= 1'b0;
      mem_is_rd   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_vld) begin
            mem_is_rd   <= req_is_rd;
            mem_addr    <= ADDR_W'(line_align(64'(req_addr), BLOCK_SIZE));
            line        <= req_is_rd ? '0 : req_wline;
            mem_cmd_vld <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_cmd_rdy) begin
            if (mem_is_rd) begin
              mem_cmd_vld <= 1'b0;
              mem_rd_rdy  <= 1'b1;
              state       <= RD_XFER;
            end else begin
              // Write beats reuse the command channel, so valid stays high.
              mem_wdata <= line[0 +: DATA_WIDTH];
              state     <= WR_XFER;
            end
          end
        end
        WR_XFER: begin
          if (mem_cmd_rdy) begin
            if (last_beat) begin
              mem_cmd_vld <= 1'b0;
              mem_wdata   <= '0;
              resp_vld    <= 1'b1;
              resp_rline  <= '0;
              state       <= RESP;
            end else begin
              mem_wdata <= line[next_beat*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        RD_XFER: begin
          if (mem_rd_vld) begin
            line <= fill_line;
            if (last_beat) begin
              mem_rd_rdy <= 1'b0;
              resp_vld   <= 1'b1;
              resp_rline <= fill_line;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          if (resp_rdy) begin
            resp_vld <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRAM_LINE_ENGINE_PERF_EN
  logic xfer_stall;
  logic resp_hs;

  assign xfer_stall = ((state == WR_XFER) && !mem_cmd_rdy) || ((state == RD_XFER) && !mem_rd_vld);
  assign resp_hs    = (state == RESP) && resp_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_cnt    <= '0;
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (resp_hs && mem_is_rd && (perf_rd_cnt != '1)) perf_rd_cnt <= perf_rd_cnt + 32'd1;
      if (resp_hs && !mem_is_rd && (perf_wr_cnt != '1)) perf_wr_cnt <= perf_wr_cnt + 32'd1;
      if (xfer_stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_line_engine.sv
// Self-checking bench for dram_line_engine: directed vector table, corner sequences, random transfers.
module tb_dram_line_engine;

  localparam int DW = 8;
  localparam int BS = 32;
  localparam int AW = 32;
  localparam int LW = DW * BS;

  logic          clk;
  logic          rst;
  logic          req_vld;
  logic          req_rdy;
  logic          req_is_rd;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_wline;
  logic          resp_vld;
  logic          resp_rdy;
  logic [LW-1:0] resp_rline;
  logic          mem_is_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_cmd_vld;
  logic          mem_cmd_rdy;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd_rdy;
  logic          mem_rd_vld;
  logic [DW-1:0] mem_rdata;
  logic [2:0]    dbg_state;
`ifdef DRAM_LINE_ENGINE_PERF_EN
  logic [31:0]   perf_rd_cnt;
  logic [31:0]   perf_wr_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  dram_line_engine #(
    .DATA_WIDTH(DW),
    .BLOCK_SIZE(BS),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_is_rd  (req_is_rd),
    .req_addr   (req_addr),
    .req_wline  (req_wline),
    .resp_vld   (resp_vld),
    .resp_rdy   (resp_rdy),
    .resp_rline (resp_rline),
    .mem_is_rd  (mem_is_rd),
    .mem_addr   (mem_addr),
    .mem_cmd_vld(mem_cmd_vld),
    .mem_cmd_rdy(mem_cmd_rdy),
    .mem_wdata  (mem_wdata),
    .mem_rd_rdy (mem_rd_rdy),
    .mem_rd_vld (mem_rd_vld),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
`ifdef DRAM_LINE_ENGINE_PERF_EN
    ,
    .perf_rd_cnt   (perf_rd_cnt),
    .perf_wr_cnt   (perf_wr_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int sh_rd    = 0;
  int sh_wr    = 0;
  int sh_stall = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] make_line(input logic [7:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < BS; i++) l[i*DW +: DW] = base + 8'(i);
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, 256'({req_rdy, resp_vld, mem_cmd_vld, mem_rd_rdy, mem_is_rd, mem_addr, mem_wdata}),
          256'({1'b1, 4'b0000, 32'h0, 8'h00}));
    check({name, "_rline"}, 256'(resp_rline), 256'(0));
  endtask

  task automatic check_perf();
`ifdef DRAM_LINE_ENGINE_PERF_EN
    check("perf_rd_cnt", 256'(perf_rd_cnt), 256'(sh_rd));
    check("perf_wr_cnt", 256'(perf_wr_cnt), 256'(sh_wr));
    check("perf_stall_cnt", 256'(perf_stall_cnt), 256'(sh_stall));
`endif
  endtask

  // ---------------- driver + DRAM model + scoreboard ----------------
  // mode: 0 DRAM always ready, 1 cmd_rdy toggles 1,0,1,..., 2 read gap of 5 after 11 beats,
  // 3 random waits on every channel. abort_at >= 0 asserts rst once that many beats are done.
  task automatic run_txn(input bit is_rd, input logic [AW-1:0] addr, input logic [LW-1:0] data,
                         input logic [AW-1:0] exp_addr, input int mode, input int resp_wait,
                         input bit hold_req, input bit spur, input int abort_at, input int exp_cycles);
    logic [DW-1:0] exp_q[$];
    logic [LW-1:0] exp_line;
    int            k;
    int            cyc;
    int            stalls;
    int            rd_gap;
    bit            issued;
    bit            in_xfer;
    bit            tog;
    bit            crdy;
    bit            vld;
    bit            hs;

    exp_line = is_rd ? data : '0;
    exp_q.delete();
    if (!is_rd) for (int i = 0; i < BS; i++) exp_q.push_back(data[i*DW +: DW]);

    check("req_rdy_idle", 256'(req_rdy), 256'(1));
    req_vld   = 1'b1;
    req_is_rd = is_rd;
    req_addr  = addr;
    req_wline = is_rd ? rand_line() : data;
    tick();
    req_vld   = 1'b0;
    req_wline = rand_line();
    check("mem_addr", 256'(mem_addr), 256'(exp_addr));
    check("mem_is_rd", 256'(mem_is_rd), 256'(is_rd));

    cyc = 1; k = 0; stalls = 0; rd_gap = 0; issued = 1'b0; tog = 1'b1;
    for (int c = 0; c < 400 && !resp_vld; c++) begin
      if (abort_at >= 0 && issued && k == abort_at) begin
        rst        = 1'b1;
        mem_rd_vld = 1'b1;
        mem_rdata  = 8'($urandom);
        tick();
        rst        = 1'b0;
        mem_rd_vld = 1'b0;
        check_reset_outputs("abort");
        sh_rd = 0; sh_wr = 0; sh_stall = 0;
        check_perf();
        return;
      end
      in_xfer = issued;
      case (mode)
        1:       crdy = tog;
        3:       crdy = 1'($urandom_range(0, 1));
        default: crdy = 1'b1;
      endcase
      tog = !tog;
      mem_cmd_rdy = crdy;
      if (mem_rd_rdy) begin
        vld = 1'b1;
        if (mode == 2 && k == 11 && rd_gap < 5) begin
          vld = 1'b0;
          rd_gap++;
        end
        if (mode == 3) vld = 1'($urandom_range(0, 1));
        mem_rd_vld = vld;
        mem_rdata  = (vld && k < BS) ? data[k*DW +: DW] : 8'($urandom);
      end else begin
        vld        = 1'b0;
        mem_rd_vld = spur && ($urandom_range(0, 1) == 1);
        mem_rdata  = 8'($urandom);
      end

      if (!issued) begin
        check("issue_cmd_vld", 256'({mem_cmd_vld, mem_rd_rdy}), 256'(2'b10));
        if (mem_cmd_vld && crdy) issued = 1'b1;
        hs = 1'b0;
      end else if (is_rd) begin
        check("rd_xfer_rdy", 256'({mem_rd_rdy, mem_cmd_vld}), 256'(2'b10));
        hs = mem_rd_rdy && vld;
      end else begin
        check("wr_xfer_vld", 256'(mem_cmd_vld), 256'(1));
        if (exp_q.size() > 0) check("wr_wdata", 256'(mem_wdata), 256'(exp_q[0]));
        hs = mem_cmd_vld && crdy;
      end

      if (in_xfer) begin
        if (hs) begin
          k++;
          if (!is_rd && exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          stalls++;
        end
      end
      tick();
      cyc++;
    end

    mem_cmd_rdy = 1'b0;
    mem_rd_vld  = 1'b0;
    check("resp_timeout", 256'(resp_vld), 256'(1));
    check("beat_count", 256'(k), 256'(BS));
    if (!is_rd) check("wr_queue_empty", 256'(exp_q.size()), 256'(0));
    if (exp_cycles > 0) check("occupancy", 256'(cyc), 256'(exp_cycles));

    for (int i = 0; i < resp_wait; i++) begin
      if (hold_req) begin
        req_vld   = 1'b1;
        req_is_rd = is_rd;
        req_addr  = addr;
        req_wline = is_rd ? rand_line() : data;
      end
      mem_rd_vld = spur;
      check("resp_hold_vld", 256'({resp_vld, req_rdy, mem_cmd_vld, mem_rd_rdy}), 256'(4'b1000));
      check("resp_hold_line", resp_rline, exp_line);
      tick();
    end
    mem_rd_vld = 1'b0;
    resp_rdy   = 1'b1;
    check("resp_line", resp_rline, exp_line);
    check("resp_vld", 256'(resp_vld), 256'(1));
    tick();
    resp_rdy = 1'b0;
    if (is_rd) sh_rd++;
    else sh_wr++;
    sh_stall += stalls;
    check("post_resp", 256'({req_rdy, resp_vld}), 256'(2'b10));
    check_perf();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            is_rd;
    logic [AW-1:0] addr;
    logic [7:0]    base;
    int            mode;
    int            resp_wait;
    logic [AW-1:0] exp_addr;
    int            exp_cycles;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [LW-1:0] keep_line;
    logic [AW-1:0] ra;
    bit            rrd;

    rst = 1'b1; req_vld = 1'b0; req_is_rd = 1'b0; req_addr = '0; req_wline = '0;
    resp_rdy = 1'b0; mem_cmd_rdy = 1'b0; mem_rd_vld = 1'b0; mem_rdata = '0;

    vecs[0] = '{1'b1, 32'h0000_0047, 8'h00, 0, 0, 32'h0000_0040, 34};
    vecs[1] = '{1'b0, 32'h0000_0080, 8'hA0, 1, 0, 32'h0000_0080, 66};
    vecs[2] = '{1'b1, 32'h1234_567F, 8'h10, 2, 1, 32'h1234_5660, 39};
    vecs[3] = '{1'b0, 32'hFFFF_FFE5, 8'hF0, 0, 2, 32'hFFFF_FFE0, 34};

    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_reset_outputs("after_reset");
    check_perf();

    for (int v = 0; v < 4; v++) begin
      run_txn(vecs[v].is_rd, vecs[v].addr, make_line(vecs[v].base), vecs[v].exp_addr,
              vecs[v].mode, vecs[v].resp_wait, 1'b0, 1'b0, -1, vecs[v].exp_cycles);
    end

    // Request held through a stalled response, then accepted right after the handshake.
    run_txn(1'b1, 32'h0000_0200, make_line(8'h30), 32'h0000_0200, 0, 3, 1'b1, 1'b0, -1, 34);
    run_txn(1'b1, 32'h0000_0200, make_line(8'h30), 32'h0000_0200, 0, 0, 1'b0, 1'b0, -1, 34);

    // Reset in the middle of a fill, then a clean fill.
    run_txn(1'b1, 32'h0000_0300, make_line(8'h55), 32'h0000_0300, 0, 0, 1'b0, 1'b0, 12, 0);
    run_txn(1'b1, 32'h0000_0345, make_line(8'h60), 32'h0000_0340, 0, 0, 1'b0, 1'b0, -1, 34);

    // Spurious read beats while idle must not disturb anything.
    keep_line = make_line(8'h60);
    for (int i = 0; i < 4; i++) begin
      mem_rd_vld = 1'b1;
      mem_rdata  = 8'($urandom);
      tick();
      check("spur_idle", 256'({req_rdy, resp_vld, mem_rd_rdy, mem_cmd_vld}), 256'(4'b1000));
      check("spur_idle_line", resp_rline, keep_line);
    end
    mem_rd_vld = 1'b0;
    run_txn(1'b1, 32'h0000_0400, make_line(8'h77), 32'h0000_0400, 3, 1, 1'b0, 1'b1, -1, 0);

    // Randomized transfers against the line-level reference.
    for (int t = 0; t < 24; t++) begin
      rrd = 1'($urandom_range(0, 1));
      ra  = $urandom;
      run_txn(rrd, ra, rand_line(), ra & ~32'h1F, 3, $urandom_range(0, 3), 1'b0,
              1'($urandom_range(0, 1)), -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
